// File: rtl/cache_bist_pkg.sv
// Shared types and helpers for the cache BIST: FSM state encoding,
// cache write-enable codes and the deterministic test pattern.
// The byte-lane states exist only when CACHE_BIST_BYTE_WRITE_EN is defined.
package cache_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ISSUE,
      ST_WR_WAIT,
      ST_RD_ISSUE,
      ST_RD_WAIT,
`ifdef CACHE_BIST_BYTE_WRITE_EN
      ST_BYTE_ISSUE,
      ST_BYTE_WAIT,
      ST_BYTE_READ,
      ST_BYTE_CHECK,
`endif
      ST_DONE
   } state_e;

   localparam logic [3:0] WeNone  = 4'b0000;
   localparam logic [3:0] WeByte0 = 4'b0001;
   localparam logic [3:0] WeWord  = 4'b1111;

   // Value written into byte lane 0 during the byte-lane pass.
   localparam logic [7:0] BytePattern = 8'h5A;

   // pat(i) = seed ^ (i * stride), truncated to 32 bits.
   function automatic logic [31:0] pattern(input logic [31:0] index,
                                           input logic [31:0] seed,
                                           input logic [31:0] stride);
      return seed ^ (index * stride);
   endfunction

endpackage

// File: rtl/cache_bist_if.sv
// CPU-side cache port as seen by the BIST. The BIST is the master;
// the cache (or a bench model of it) is the slave.
interface cache_bist_if;

   logic        c_enable;
   logic [3:0]  c_write_enable;
   logic [31:0] c_address;
   logic [31:0] c_data_in;
   logic [31:0] c_data_out;
   logic        c_data_out_ready;
   logic        c_busy;

   modport master (
      output c_enable, c_write_enable, c_address, c_data_in,
      input  c_data_out, c_data_out_ready, c_busy
   );

   modport slave (
      input  c_enable, c_write_enable, c_address, c_data_in,
      output c_data_out, c_data_out_ready, c_busy
   );

endinterface

// File: rtl/cache_bist_checker.sv
// Read-back comparator: counts mismatches (saturating at 16'hFFFF) and
// captures address / expected / actual of the first mismatch since clear.
module cache_bist_checker (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        sample,
   input  logic [31:0] address,
   input  logic [31:0] expected,
   input  logic [31:0] actual,
   output logic [15:0] error_count,
   output logic [31:0] fail_address,
   output logic [31:0] fail_expected,
   output logic [31:0] fail_actual
);

   logic [15:0] err_cnt_q, err_cnt_d;
   logic [31:0] fail_addr_q, fail_addr_d;
   logic [31:0] fail_exp_q, fail_exp_d;
   logic [31:0] fail_act_q, fail_act_d;
   logic        mismatch;

   assign mismatch = sample && (actual != expected);

   // Next-state for the error counter and first-failure capture.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      fail_exp_d  = fail_exp_q;
      fail_act_d  = fail_act_q;
      if (clear) begin
         err_cnt_d   = '0;
         fail_addr_d = '0;
         fail_exp_d  = '0;
         fail_act_d  = '0;
      end else if (mismatch) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         if (err_cnt_q == 16'd0) begin
            fail_addr_d = address;
            fail_exp_d  = expected;
            fail_act_d  = actual;
         end
      end
   end

   // Capture registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_act_q  <= '0;
      end else begin
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_exp_q  <= fail_exp_d;
         fail_act_q  <= fail_act_d;
      end
   end

   assign error_count   = err_cnt_q;
   assign fail_address  = fail_addr_q;
   assign fail_expected = fail_exp_q;
   assign fail_actual   = fail_act_q;

endmodule

// File: rtl/cache_bist.sv
// Cache built-in self-test: writes pat(i) to BaseAddress + 4*i for every
// word, then reads each word back and compares it.
// Optional macro CACHE_BIST_BYTE_WRITE_EN adds a byte-lane-0 write and
// read-back pass after the read pass.
// All cache-port outputs are registered; an issue is visible on the port
// the cycle after the FSM sees !c_busy, so the first cycle of each wait
// state is skipped (the cache has not reacted yet and any data_out_ready
// there is stale).
module cache_bist
   import cache_bist_pkg::*;
#(
   parameter logic [31:0] BaseAddress = 32'd0,
   parameter int unsigned WordCount   = 16,
   parameter logic [31:0] Seed        = 32'hA5C3_0F1E,
   parameter logic [31:0] Stride      = 32'h9E37_79B9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        running,
   output logic        done,
   output logic        pass,
   output logic [15:0] error_count,
   output logic [31:0] fail_address,
   output logic [31:0] fail_expected,
   output logic [31:0] fail_actual,
   cache_bist_if.master cbus
);

   localparam logic [16:0] LastIdx = 17'(WordCount - 1);

   state_e      state_q, state_d;
   logic [16:0] idx_q, idx_d;
   logic        skip_q, skip_d;
   logic        en_q, en_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] din_q, din_d;
   logic        done_q, done_d;

   logic [31:0] cur_addr;
   logic [31:0] cur_pat;
   logic [31:0] cmp_expected;
   logic        last_word;
   logic        start_ok;
   logic        sample;

   assign cur_addr  = BaseAddress + {13'd0, idx_q, 2'b00};
   assign cur_pat   = pattern({15'd0, idx_q}, Seed, Stride);
   assign last_word = (idx_q == LastIdx);
   assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef CACHE_BIST_BYTE_WRITE_EN
   assign sample       = ((state_q == ST_RD_WAIT) || (state_q == ST_BYTE_CHECK)) &&
                         !skip_q && cbus.c_data_out_ready;
   assign cmp_expected = (state_q == ST_BYTE_CHECK) ? {cur_pat[31:8], BytePattern} : cur_pat;
`else
   assign sample       = (state_q == ST_RD_WAIT) && !skip_q && cbus.c_data_out_ready;
   assign cmp_expected = cur_pat;
`endif

   // FSM next-state and registered cache-port outputs.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      skip_d  = 1'b0;
      en_d    = en_q;
      we_d    = WeNone;
      addr_d  = addr_q;
      din_d   = din_q;
      done_d  = done_q;
      if (start_ok) begin
         state_d = ST_WR_ISSUE;
         idx_d   = '0;
         en_d    = 1'b1;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_WR_ISSUE: if (!cbus.c_busy) begin
               addr_d  = cur_addr;
               din_d   = cur_pat;
               we_d    = WeWord;
               skip_d  = 1'b1;
               state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: if (!skip_q && !cbus.c_busy) begin
               if (last_word) begin
                  idx_d   = '0;
                  state_d = ST_RD_ISSUE;
               end else begin
                  idx_d   = idx_q + 17'd1;
                  state_d = ST_WR_ISSUE;
               end
            end
            ST_RD_ISSUE: if (!cbus.c_busy) begin
               addr_d  = cur_addr;
               skip_d  = 1'b1;
               state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (sample) begin
               if (last_word) begin
                  idx_d = '0;
`ifdef CACHE_BIST_BYTE_WRITE_EN
                  state_d = ST_BYTE_ISSUE;
`else
                  state_d = ST_DONE;
                  en_d    = 1'b0;
                  done_d  = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 17'd1;
                  state_d = ST_RD_ISSUE;
               end
            end
`ifdef CACHE_BIST_BYTE_WRITE_EN
            ST_BYTE_ISSUE: if (!cbus.c_busy) begin
               addr_d  = cur_addr;
               din_d   = {cur_pat[31:8], BytePattern};
               we_d    = WeByte0;
               skip_d  = 1'b1;
               state_d = ST_BYTE_WAIT;
            end
            ST_BYTE_WAIT: if (!skip_q && !cbus.c_busy) state_d = ST_BYTE_READ;
            ST_BYTE_READ: if (!cbus.c_busy) begin
               addr_d  = cur_addr;
               skip_d  = 1'b1;
               state_d = ST_BYTE_CHECK;
            end
            ST_BYTE_CHECK: if (sample) begin
               if (last_word) begin
                  state_d = ST_DONE;
                  en_d    = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 17'd1;
                  state_d = ST_BYTE_ISSUE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // FSM and output registers; reset overrides a run in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         skip_q  <= 1'b0;
         en_q    <= 1'b0;
         we_q    <= WeNone;
         addr_q  <= '0;
         din_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         skip_q  <= skip_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         done_q  <= done_d;
      end
   end

   cache_bist_checker u_checker (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (start_ok),
      .sample        (sample),
      .address       (cur_addr),
      .expected      (cmp_expected),
      .actual        (cbus.c_data_out),
      .error_count   (error_count),
      .fail_address  (fail_address),
      .fail_expected (fail_expected),
      .fail_actual   (fail_actual)
   );

   assign running             = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done                = done_q;
   assign pass                = done_q && (error_count == 16'd0);
   assign cbus.c_enable       = en_q;
   assign cbus.c_write_enable = we_q;
   assign cbus.c_address      = addr_q;
   assign cbus.c_data_in      = din_q;

endmodule

// File: doc/cache_bist.md
Name: cache_bist

Overview:
- Built-in self-test initiator that drives the CPU-side port of the cache (enable / write_enable / address / data_in in; data_out / data_out_ready / busy back).
- Walks a configurable word range: a write pass of a deterministic pattern, then a read-back-and-compare pass.
- Used for PSRAM bring-up on the board, and as a synthesizable traffic generator in cache + burst_ram benches.
- Reports pass/fail, error count and first-failure capture.

Parameters:
- BaseAddress, 0, byte address of the first word tested; must be 4-byte aligned.
- WordCount, 16, number of 32-bit words tested (1..2^16).
- Seed, 32'hA5C3_0F1E, pattern seed.
- Stride, 32'h9E37_79B9, pattern multiplier.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; starts a run when idle
- running  out  1  run in progress
- done  out  1  run finished; held until next start or reset
- pass  out  1  valid when done; 1 = zero mismatches
- error_count  out  16  mismatches seen; saturates at 16'hFFFF
- fail_address  out  32  address of first mismatch
- fail_expected  out  32  expected word at first mismatch
- fail_actual  out  32  read word at first mismatch
- c_enable  out  1  to cache enable
- c_write_enable  out  4  to cache write_enable
- c_address  out  32  to cache address
- c_data_in  out  32  to cache data_in
- c_data_out  in  32  from cache data_out
- c_data_out_ready  in  1  from cache data_out_ready
- c_busy  in  1  from cache busy

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset is synchronous and overrides everything, including mid-run: FSM returns to IDLE, capture registers are cleared, c_write_enable is 0 on the next edge.
- Pattern: pat(i) = Seed ^ (i * Stride)[31:0] for word index i in 0..WordCount-1.
- Address: addr(i) = BaseAddress + 4*i, computed modulo 2^32.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, (BYTE_* optional), DONE.
- IDLE:
  - c_enable = 0.
  - start -> clear counters and capture registers; i = 0; go to WR_ISSUE.
  - start in any other state is ignored.
- WR_ISSUE:
  - c_enable = 1.
  - Wait while c_busy.
  - In the first cycle with !c_busy, drive c_address = addr(i), c_data_in = pat(i), c_write_enable = 4'b1111 for exactly that one cycle, then go to WR_WAIT.
- WR_WAIT:
  - c_write_enable = 0; c_address is held.
  - The cycle after issue is never treated as idle.
  - Next cycle with !c_busy: i++. If i == WordCount, reset i = 0 and go to RD_ISSUE; else go to WR_ISSUE.
- RD_ISSUE:
  - First cycle with !c_busy: drive c_address = addr(i), c_write_enable = 0; go to RD_WAIT.
- RD_WAIT:
  - Cycle after issue with c_data_out_ready (hit) or later (miss): sample c_data_out and compare with pat(i).
  - On mismatch, increment error_count. If it is the first mismatch, latch fail_address, fail_expected and fail_actual.
  - i++. At the end of the range go to DONE; else go to RD_ISSUE.
  - c_data_out_ready seen in the issue cycle itself is ignored (stale data).
- DONE:
  - c_enable = 0.
  - done = 1; pass = (error_count == 0).
  - start -> begins a new run (same as from IDLE).
- running = 1 in every state except IDLE and DONE.
- Latency per word: hit read = 2 cycles (issue + sample); a miss adds the cache's refill time.
- WordCount = 1 is legal: a single write, then a single read.
- Address wrap past 2^32 is not checked and is a parameter error.

Optional Feature:
- Macro CACHE_BIST_BYTE_WRITE_EN.
- When defined, a byte-lane pass runs after the read pass, per word:
  - BYTE_ISSUE: write data 32'hxxxx_xx5A with c_write_enable = 4'b0001, then wait !c_busy.
  - BYTE_CHECK: read the word and compare with {pat(i)[31:8], 8'h5A}.
  - Mismatches are counted and captured as in RD_WAIT.
- When undefined, the BYTE states are not compiled and RD_WAIT goes straight to DONE at the end of the range.

Decomposition:
- Package cache_bist_pkg holds:
  - state enum type;
  - the write-enable constants WeNone = 4'b0000, WeByte0 = 4'b0001, WeWord = 4'b1111;
  - function pattern(index, seed, stride).
- One sub-module, cache_bist_checker: compare, error_count saturation and first-fail capture. Inputs: sample strobe, address, expected, actual, clear.

Test Plan:
- cache + burst_ram bench (LineIndexBitWidth = 1, RamAddressingMode = 3), BaseAddress = 0, WordCount = 16, pulse start -> done within 2000 cycles, pass = 1, error_count = 0.
- BaseAddress = 64, WordCount = 16 (forces evictions of dirty lines) -> pass = 1; word 1 in RAM reads back as 32'hA5C3_0F1E ^ 32'h9E37_79B9 = 32'h3BF4_76A7.
- Bench forces c_data_out to 32'hDEAD_BEEF on the read of word 3 -> pass = 0, error_count = 1, fail_address = 12, fail_expected = pat(3), fail_actual = 32'hDEAD_BEEF.
- Assert rst_n = 0 for one cycle during WR_WAIT -> next cycle running = 0, c_write_enable = 0, done = 0; a fresh start then completes with pass = 1.
- start pulsed while running -> ignored; error_count is unchanged and the run finishes once.
- With CACHE_BIST_BYTE_WRITE_EN, WordCount = 4 -> read of word 0 returns {pat(0)[31:8], 8'h5A} = 32'hA5C3_0F5A; pass = 1.
